// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph codes and the receiver FSM state type.
// These glyph constants are the ones the hex-to-segment display encoder drives.
package seg7_pkg;

    // Active-low codes: bit0 top .. bit6 middle, 0 = segment lit.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE,
        LOCKED
    } state_t;

endpackage

// File: rtl/seg7_lookup.sv
// Combinational reverse lookup: segment pattern -> {hit, digit}.
// Only the exact encoder glyphs are recognised; anything else reports hit = 0.
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] digit
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        hit   = 1'b1;
        digit = 4'h0;
        case (seg)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decode.sv
// Seven-segment receiver: debounces seg_in for STABLE_CYCLES, then reports digit, blank or illegal.
// Define SEG7_DECODE_ERRCNT_EN to build the saturating illegal-pattern counter behind err_count.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    output logic [3:0]       hex_out,
    output logic             hex_valid,
    output logic             blank,
    output logic             bad_pattern,
    output logic [ERR_W-1:0] err_count
);

    localparam int             CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       s;
    logic [CNT_W-1:0] cnt, cnt_next;
    state_t           state, state_next;
    logic [3:0]       hex_next;
    logic             valid_next, blank_next, bad_next;
    logic             hit;
    logic [3:0]       digit;

    seg7_lookup u_lookup (
        .seg   (s),
        .hit   (hit),
        .digit (digit)
    );

    // A change always wins, even on what would have been the decision edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hex_next   = hex_out;
        valid_next = 1'b0;
        blank_next = blank;
        bad_next   = 1'b0;
        if (seg_in != s) begin
            cnt_next   = CNT_ONE;
            state_next = SETTLE;
            blank_next = 1'b0;
        end else if (state == SETTLE) begin
            if (cnt == CNT_MAX) begin
                state_next = LOCKED;
                if (hit) begin
                    hex_next   = digit;
                    valid_next = 1'b1;
                end else if (s == SEG_BLANK) begin
                    blank_next = 1'b1;
                end else begin
                    bad_next   = 1'b1;
                end
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s           <= SEG_BLANK;
            cnt         <= '0;
            state       <= SETTLE;
            hex_out     <= 4'h0;
            hex_valid   <= 1'b0;
            blank       <= 1'b0;
            bad_pattern <= 1'b0;
        end else begin
            s           <= seg_in;
            cnt         <= cnt_next;
            state       <= state_next;
            hex_out     <= hex_next;
            hex_valid   <= valid_next;
            blank       <= blank_next;
            bad_pattern <= bad_next;
        end
    end

`ifdef SEG7_DECODE_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (bad_next && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_decode.sv
// Self-checking bench for seg7_decode: directed table and sequences plus randomized runs
// against a run-length reference model; a second instance with ERR_W=2 checks saturation.
module tb_seg7_decode;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [3:0] hex_a, hex_b;
    logic       valid_a, valid_b, blank_a, blank_b, bad_a, bad_b;
    logic [7:0] err_a;
    logic [1:0] err_b;

    seg7_decode #(.STABLE_CYCLES(N), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .hex_out(hex_a), .hex_valid(valid_a),
        .blank(blank_a), .bad_pattern(bad_a), .err_count(err_a)
    );

    seg7_decode #(.STABLE_CYCLES(N), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .hex_out(hex_b), .hex_valid(valid_b),
        .blank(blank_b), .bad_pattern(bad_b), .err_count(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] code;
        logic [3:0] digit;
    } vec_t;

    vec_t vecs [16];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a pattern is reported on its (N+1)th consecutive identical sample.
    int         run;
    logic [6:0] last;
    logic [3:0] m_hex;
    bit         m_valid, m_blank, m_bad;
    int         m_err8, m_err2;

    int tick_no, pv, pb, first_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int digit_of(input logic [6:0] v);
        for (int i = 0; i < 16; i++)
            if (vecs[i].code == v) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [6:0] v, input bit r);
        int d;
        if (r) begin
            run = 0; m_hex = 0; m_valid = 0; m_blank = 0; m_bad = 0; m_err8 = 0; m_err2 = 0;
        end else begin
            m_valid = 0;
            m_bad   = 0;
            if (run == 0 || v != last) begin
                run = 1; last = v; m_blank = 0;
            end else if (run <= N) begin
                run++;
                if (run == N + 1) begin
                    d = digit_of(v);
                    if (d >= 0) begin
                        m_hex = 4'(d); m_valid = 1;
                    end else if (v == 7'h7F) begin
                        m_blank = 1;
                    end else begin
                        m_bad = 1;
`ifdef SEG7_DECODE_ERRCNT_EN
                        if (m_err8 < 255) m_err8++;
                        if (m_err2 < 3) m_err2++;
`endif
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic [6:0] v, input bit r);
        seg_in = v;
        rst    = r;
        @(posedge clk);
        model_edge(v, r);
        @(negedge clk);
        tick_no++;
        if (valid_a) begin
            pv++;
            if (first_valid < 0) first_valid = tick_no;
        end
        if (bad_a) pb++;
        check("hex_out",     32'(hex_a),   32'(m_hex));
        check("hex_valid",   32'(valid_a), 32'(m_valid));
        check("blank",       32'(blank_a), 32'(m_blank));
        check("bad_pattern", 32'(bad_a),   32'(m_bad));
        check("err_count8",  32'(err_a),   32'(m_err8));
        check("err_count2",  32'(err_b),   32'(m_err2));
        check("dut2_hex",    32'(hex_b),   32'(m_hex));
    endtask

    task automatic hold(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0);
    endtask

    task automatic clr();
        tick_no = 0; pv = 0; pb = 0; first_valid = -1;
    endtask

    initial begin
        logic [6:0] codes [16];
        logic [6:0] bads [5];
        int exp3, exp8;
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        bads  = '{7'h55, 7'h2A, 7'h7E, 7'h01, 7'h5A};
        for (int i = 0; i < 16; i++) begin
            vecs[i].code  = codes[i];
            vecs[i].digit = 4'(i);
        end
`ifdef SEG7_DECODE_ERRCNT_EN
        exp3 = 3; exp8 = 8;
`else
        exp3 = 0; exp8 = 0;
`endif
        run = 0; last = 7'h7F;
        clr();

        // Reset state, then the all-off input settles into blank after N+1 edges.
        tick(7'h7F, 1'b1);
        tick(7'h7F, 1'b1);
        check("rst_hex",   32'(hex_a),   0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_blank", 32'(blank_a), 0);
        check("rst_err",   32'(err_a),   0);
        hold(7'h7F, N);
        check("blank_pre",  32'(blank_a), 0);
        tick(7'h7F, 1'b0);
        check("blank_post", 32'(blank_a), 1);

        // Single steady digit: exactly one pulse on the 5th edge.
        clr();
        hold(7'h24, 10);
        check("lat24_edge",  32'(first_valid), N + 1);
        check("lat24_count", 32'(pv), 1);
        check("lat24_hex",   32'(hex_a), 2);

        // Table walk through all 16 legal glyphs.
        for (int i = 0; i < 16; i++) begin
            clr();
            hold(vecs[i].code, 6);
            check("tbl_pulses", 32'(pv), 1);
            check("tbl_digit",  32'(hex_a), 32'(vecs[i].digit));
            check("tbl_nobad",  32'(pb), 0);
        end

        // Blank after a digit, then recover to a digit.
        hold(7'h30, 6);
        clr();
        hold(7'h7F, N);
        check("blk_pre", 32'(blank_a), 0);
        tick(7'h7F, 1'b0);
        check("blk_rise",  32'(blank_a), 1);
        check("blk_hex3",  32'(hex_a), 3);
        check("blk_noval", 32'(pv), 0);
        hold(7'h7F, 1);
        tick(7'h40, 1'b0);
        check("blk_drop", 32'(blank_a), 0);
        clr();
        hold(7'h40, N);
        check("blk_then0_pulse", 32'(pv), 1);
        check("blk_then0_hex",   32'(hex_a), 0);

        // Illegal patterns and counter saturation.
        tick(7'h00, 1'b1);
        clr();
        for (int k = 0; k < 3; k++) begin
            hold(7'h00, 6);
            hold(7'h55, 6);
        end
        check("bad_pulses", 32'(pb), 3);
        check("err8_three", 32'(err_a), 32'(exp3));
        for (int k = 0; k < 5; k++) begin
            hold(7'h00, 6);
            hold(bads[k], 6);
        end
        check("err2_sat", 32'(err_b), 32'(exp3));
        check("err8_8",   32'(err_a), 32'(exp8));

        // Short glitch then a settled digit; change exactly on the decision edge.
        hold(7'h00, 6);
        clr();
        hold(7'h79, 3);
        hold(7'h12, 6);
        check("glitch_pulses", 32'(pv), 1);
        check("glitch_hex",    32'(hex_a), 5);
        clr();
        hold(7'h19, N);
        hold(7'h30, 6);
        check("race_pulses", 32'(pv), 1);
        check("race_hex",    32'(hex_a), 3);

        // Reset mid-settle discards everything.
        hold(7'h19, 2);
        tick(7'h19, 1'b1);
        check("mid_rst_hex",   32'(hex_a), 0);
        check("mid_rst_valid", 32'(valid_a), 0);
        check("mid_rst_bad",   32'(bad_a), 0);
        check("mid_rst_err",   32'(err_a), 0);
        clr();
        hold(7'h19, 6);
        check("post_rst_edge", 32'(first_valid), N + 1);
        check("post_rst_hex",  32'(hex_a), 4);

        // Randomized segments against the model.
        for (int i = 0; i < 150; i++) begin
            int sel;
            logic [6:0] v;
            sel = $urandom_range(0, 99);
            if (sel < 50)      v = vecs[$urandom_range(0, 15)].code;
            else if (sel < 65) v = 7'h7F;
            else               v = 7'($urandom);
            hold(v, $urandom_range(1, 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
